// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the round-robin stream arbiter.
//   N_REQ_DEF  - default number of requesters
//   WIDTH_DEF  - default data width per requester
//   next_idx() - (idx+1) mod n, used for the rotating priority pointer
//                by the RTL and by the testbench model alike.
package rr_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    function automatic int unsigned next_idx(input int unsigned idx,
                                             input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: purely combinational rotating-priority search.
// Scans req_valid starting at index ptr and wrapping N_REQ-1 -> 0; the
// first set bit wins.
// Ports:
//   req_valid   in  [N_REQ-1:0]  candidate requests
//   ptr         in  [IDX_W-1:0]  index with highest priority this cycle
//   grant_valid out              at least one request present
//   grant_idx   out [IDX_W-1:0]  winning index (0 when no grant)
//   grant_oh    out [N_REQ-1:0]  one-hot of the winner (0 when no grant)
module rr_priority_picker #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_oh
);

    int j;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        j           = 0;
        // k is the distance from ptr; the first hit in distance order wins.
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!grant_valid && req_valid[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
                grant_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin arbiter sharing one registered output
// channel among N_REQ valid/ready requesters.
//
// Handshake: a beat moves across an interface in the cycle where both
// valid and ready are high at the rising clock edge. Producers hold valid
// and data stable until ready; ready never depends on a valid being
// withdrawn.
//
// Ports:
//   clk        in                 rising-edge clock
//   rst_n      in                 asynchronous active-low reset
//   req_valid  in  [N_REQ-1:0]    per-requester valid
//   req_data   in  [N_REQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   req_ready  out [N_REQ-1:0]    at most one bit high (the granted one)
//   out_valid  out                output register holds a beat
//   out_data   out [WIDTH-1:0]    registered data
//   out_src    out [IDX_W-1:0]    requester that produced out_data
//   out_ready  in                 consumer accepts the beat
//   req_last   in  [N_REQ-1:0]    (RR_ARB_PACKET_LOCK_EN only) end of packet
//   out_last   out                (RR_ARB_PACKET_LOCK_EN only) registered last
//
// Build option RR_ARB_PACKET_LOCK_EN: once a beat with last=0 is accepted
// the grant is locked to that requester until its last beat is accepted;
// only then does the priority pointer move on.
module rr_stream_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
`ifdef RR_ARB_PACKET_LOCK_EN
    input  logic [N_REQ-1:0]       req_last,
    output logic                   out_last,
`endif
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]       out_src,
    input  logic                   out_ready
);

    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] cand_valid;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [IDX_W-1:0] ptr_next;

`ifdef RR_ARB_PACKET_LOCK_EN
    logic             lock_active;
    logic [IDX_W-1:0] lock_idx;

    // While a packet is open only its owner may compete.
    always_comb begin
        cand_valid = req_valid;
        if (lock_active) begin
            cand_valid = req_valid & (N_REQ'(1) << lock_idx);
        end
    end
`else
    assign cand_valid = req_valid;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_valid   (cand_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh)
    );

    // The register may take a new beat when empty or when being drained.
    assign can_load = !out_valid || out_ready;

    // rst_n gates ready so nothing is offered while reset is held, even
    // though the empty register would otherwise look loadable.
    assign accept    = rst_n && can_load && grant_valid;
    assign req_ready = accept ? grant_oh : '0;

    assign sel_data = req_data[grant_idx*WIDTH +: WIDTH];
    assign ptr_next = IDX_W'(next_idx(32'(grant_idx), N_REQ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant_idx;
`ifdef RR_ARB_PACKET_LOCK_EN
            // Pointer holds on mid-packet beats so the owner keeps priority.
            if (req_last[grant_idx]) begin
                ptr <= ptr_next;
            end
`else
            ptr       <= ptr_next;
`endif
        end else if (out_ready) begin
            // Drain only; data and source keep their last values.
            out_valid <= 1'b0;
        end
    end

`ifdef RR_ARB_PACKET_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last    <= 1'b0;
            lock_active <= 1'b0;
            lock_idx    <= '0;
        end else if (accept) begin
            out_last    <= req_last[grant_idx];
            lock_active <= !req_last[grant_idx];
            lock_idx    <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: self-checking bench for rr_stream_arbiter
// (N_REQ=4, WIDTH=8). Directed vector table, hand-written reset and
// packet-lock sequences, then randomized traffic against a queue-based
// reference model. Build option RR_ARB_PACKET_LOCK_EN adds the lock test.
module tb_rr_stream_arbiter;
    import rr_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_src;
    logic           out_ready;
`ifdef RR_ARB_PACKET_LOCK_EN
    logic [N-1:0]   req_last;
    logic           out_last;
`endif

    rr_stream_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef RR_ARB_PACKET_LOCK_EN
        .req_last  (req_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [IW+W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant: first valid index at distance 0..N-1 from p.
    function automatic int ref_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [N-1:0]   valid;
        logic [N*W-1:0] data;
        logic           ordy;
        logic [N-1:0]   exp_ready;
        logic           exp_ov;
        logic [W-1:0]   exp_data;
        logic [IW-1:0]  exp_src;
        logic [IW-1:0]  exp_ptr;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*W-1:0] d,
                                input logic o, input logic [N-1:0] er,
                                input logic eov, input logic [W-1:0] ed,
                                input logic [IW-1:0] es, input logic [IW-1:0] ep);
        vec_t r;
        r.valid = v; r.data = d; r.ordy = o; r.exp_ready = er;
        r.exp_ov = eov; r.exp_data = ed; r.exp_src = es; r.exp_ptr = ep;
        return r;
    endfunction

    // ---------------- random-phase state ----------------
    logic [N-1:0] pend;
    logic [W-1:0] pdata[N];
    int           m_ptr;
    int           g;
    logic         m_can;
    logic [N-1:0] exp_rdy;
    logic [IW+W-1:0] front;

    initial begin
        // single requester, skip/wrap, rotation, backpressure, idle
        tbl[0]  = mk(4'b0100, 32'h00A5_0000, 1, 4'b0100, 1, 8'hA5, 2, 3);
        tbl[1]  = mk(4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'hA5, 2, 3);
        tbl[2]  = mk(4'b0010, 32'h0000_1100, 1, 4'b0010, 1, 8'h11, 1, 2);
        tbl[3]  = mk(4'b0100, 32'h0022_0000, 1, 4'b0100, 1, 8'h22, 2, 3);
        tbl[4]  = mk(4'b1000, 32'h3300_0000, 1, 4'b1000, 1, 8'h33, 3, 0);
        tbl[5]  = mk(4'b1111, 32'h4342_4140, 1, 4'b0001, 1, 8'h40, 0, 1);
        tbl[6]  = mk(4'b1111, 32'h4342_4140, 1, 4'b0010, 1, 8'h41, 1, 2);
        tbl[7]  = mk(4'b1111, 32'h4342_4140, 1, 4'b0100, 1, 8'h42, 2, 3);
        tbl[8]  = mk(4'b1111, 32'h4342_4140, 1, 4'b1000, 1, 8'h43, 3, 0);
        tbl[9]  = mk(4'b1111, 32'h4342_4140, 1, 4'b0001, 1, 8'h40, 0, 1);
        tbl[10] = mk(4'b1111, 32'h4342_4140, 0, 4'b0000, 1, 8'h40, 0, 1);
        tbl[11] = mk(4'b1111, 32'h4342_4140, 0, 4'b0000, 1, 8'h40, 0, 1);
        tbl[12] = mk(4'b1111, 32'h4342_4140, 0, 4'b0000, 1, 8'h40, 0, 1);
        tbl[13] = mk(4'b1111, 32'h4342_4140, 1, 4'b0010, 1, 8'h41, 1, 2);
        tbl[14] = mk(4'b0000, 32'h4342_4140, 1, 4'b0000, 0, 8'h41, 1, 2);
        tbl[15] = mk(4'b0000, 32'h4342_4140, 0, 4'b0000, 0, 8'h41, 1, 2);
        tbl[16] = mk(4'b0001, 32'h4342_4140, 0, 4'b0001, 1, 8'h40, 0, 1);
        tbl[17] = mk(4'b0000, 32'h4342_4140, 0, 4'b0000, 1, 8'h40, 0, 1);

        // ---------- reset state (requests present, ready must stay low) ----------
        req_valid = '1;
        req_data  = '0;
        out_ready = 1'b0;
`ifdef RR_ARB_PACKET_LOCK_EN
        req_last  = '1;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_ptr",       32'(dut.ptr),   32'd0);
        rst_n = 1'b1;

        // ---------- directed table ----------
        for (int i = 0; i < NV; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
            chk($sformatf("vec%0d_out_src", i),   32'(out_src),   32'(tbl[i].exp_src));
            chk($sformatf("vec%0d_ptr", i),       32'(dut.ptr),   32'(tbl[i].exp_ptr));
        end

        // ---------- async reset mid-stream ----------
        // State now: out_valid=1 (src 0), ptr=1. Stall so the beat stays.
        req_valid = 4'b1111;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_ptr",       32'(dut.ptr),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_src",   32'(out_src),   32'd0);
        chk("post_rst_out_data",  32'(out_data),  32'h40);

`ifdef RR_ARB_PACKET_LOCK_EN
        // ---------- packet lock: req0 sends 3 beats while req1 waits ----------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            req_valid   = (b < 3) ? 4'b0011 : 4'b0010;
            req_data    = 32'h0000_B0A0 | 32'(b);
            req_last[0] = (b == 2);
            req_last[1] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("lock%0d_out_src", b),  32'(out_src),  (b < 3) ? 32'd0 : 32'd1);
            chk($sformatf("lock%0d_out_last", b), 32'(out_last), (b >= 2) ? 32'd1 : 32'd0);
        end
        req_last = '1;
`endif

        // ---------- randomized traffic vs reference model ----------
        req_valid = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_ptr = 0;
        pend  = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = W'($urandom_range(0, 255));
                end
            end
            req_valid = pend;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = pdata[i];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_can   = (exp_q.size() == 0) || out_ready;
            g       = ref_grant(pend, m_ptr);
            exp_rdy = (m_can && g >= 0) ? N'(1 << g) : '0;
            chk("rand_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rand_out_valid", 32'(out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
            if (exp_q.size() != 0 && out_ready) begin
                front = exp_q.pop_front();
                chk("rand_beat", 32'({out_src, out_data}), 32'(front));
            end
            if (m_can && g >= 0) begin
                exp_q.push_back({IW'(g), pdata[g]});
                pend[g] = 1'b0;
                m_ptr   = int'(next_idx(g, N));
            end
            @(posedge clk);
            #1;
        end

        // ---------- report ----------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
